// File: rtl/flappy_frame_gen.sv
// flappy_frame_gen: Flappy Bird game logic for a GS x GS LED matrix.
// Renders each new game state into a frame and hands it to the display
// driver through a valid/done handshake.
//
// state | meaning
// IDLE  | waiting for the first flap, frame shows the bird only
// RUN   | game running, ticks move the bird and the pipe
// OVER  | bird hit the floor or the pipe, waiting for a flap to restart
module flappy_frame_gen #(
  parameter int          GS         = 8,
  parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flap_i,
  input  logic             frame_done_i,
  output logic [GS*GS-1:0] frame_o,
  output logic             frame_valid_o,
  output logic [7:0]       score_o,
  output logic             game_over_o
);

  localparam int          LW      = $clog2(GS);
  localparam logic [LW-1:0] ROW_MAX = LW'(GS - 1);
  localparam logic [LW-1:0] ROW_MID = LW'(GS / 2);
  localparam logic [LW-1:0] GAP_MAX = LW'(GS - 3);
  localparam logic [LW-1:0] GAP_ADJ = LW'(GS - 2);
  localparam logic [LW-1:0] GAP_RST = LW'(2);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   bird_row, bird_nx;
  logic [LW-1:0]   pipe_col, pipe_nx;
  logic [LW-1:0]   gap_top, gap_nx;
  logic [7:0]      lfsr, lfsr_nx;
  logic [7:0]      score_nx;
  logic [23:0]     tick_cnt;
  logic            flap_q, flap_pend, tick_pend, frame_req;
  logic            flap_edge, tick, busy, do_update, new_game;
  logic [GS*GS-1:0] frame_img;

  assign flap_edge   = flap_i & ~flap_q;
  assign tick        = (state == RUN) && (tick_cnt == TICK_COUNT - 24'd1);
  // A frame waiting to be latched counts as busy so updates never overwrite it.
  assign busy        = frame_valid_o | frame_req;
  assign do_update   = (state == RUN) && !busy && (tick || tick_pend);
  assign new_game    = (state == OVER) && flap_edge;
  assign game_over_o = (state == OVER);

  // Next-state and game update: bird, then pipe, then collision, then score.
  always_comb begin
    state_nx = state;
    bird_nx  = bird_row;
    pipe_nx  = pipe_col;
    gap_nx   = gap_top;
    lfsr_nx  = lfsr;
    score_nx = score_o;
    case (state)
      IDLE: if (flap_edge) state_nx = RUN;
      RUN: if (do_update) begin
        if (flap_pend)                bird_nx = (bird_row < LW'(2)) ? '0 : bird_row - LW'(2);
        else if (bird_row == ROW_MAX) state_nx = OVER;
        else                          bird_nx = bird_row + LW'(1);
        if (pipe_col == '0) begin
          pipe_nx = ROW_MAX;
          lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          gap_nx  = (lfsr_nx[LW-1:0] > GAP_MAX) ? lfsr_nx[LW-1:0] - GAP_ADJ : lfsr_nx[LW-1:0];
        end else begin
          pipe_nx = pipe_col - LW'(1);
        end
        if ((pipe_nx == LW'(1)) && ((bird_nx < gap_nx) || (bird_nx > gap_nx + LW'(2))))
          state_nx = OVER;
        if ((pipe_nx == '0) && (score_o != 8'hFF)) score_nx = score_o + 8'd1;
      end
      OVER: if (flap_edge) begin
        state_nx = IDLE;
        bird_nx  = ROW_MID;
        pipe_nx  = ROW_MAX;
        gap_nx   = GAP_RST;
        lfsr_nx  = 8'hA5;
        score_nx = 8'd0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Render the current game state; the pipe is hidden in IDLE.
  always_comb begin
    frame_img = '0;
    for (int r = 0; r < GS; r++) begin
      for (int c = 0; c < GS; c++) begin
        frame_img[r*GS+c] = ((c == 1) && (bird_row == LW'(r))) ||
                            ((state != IDLE) && (pipe_col == LW'(c)) &&
                             ((LW'(r) < gap_top) || (LW'(r) > gap_top + LW'(2))));
      end
    end
  end

  // State registers, tick timer, flap/tick pending flags and frame handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bird_row      <= ROW_MID;
      pipe_col      <= ROW_MAX;
      gap_top       <= GAP_RST;
      lfsr          <= 8'hA5;
      score_o       <= 8'd0;
      tick_cnt      <= 24'd0;
      flap_q        <= 1'b0;
      flap_pend     <= 1'b0;
      tick_pend     <= 1'b0;
      frame_req     <= 1'b1;
      frame_o       <= '0;
      frame_valid_o <= 1'b0;
    end else begin
      state    <= state_nx;
      bird_row <= bird_nx;
      pipe_col <= pipe_nx;
      gap_top  <= gap_nx;
      lfsr     <= lfsr_nx;
      score_o  <= score_nx;
      flap_q   <= flap_i;

      if (state == RUN) tick_cnt <= tick ? 24'd0 : tick_cnt + 24'd1;
      else              tick_cnt <= 24'd0;

      // A flap arriving with a tick is kept for the following tick.
      if (state != RUN)   flap_pend <= 1'b0;
      else if (flap_edge) flap_pend <= 1'b1;
      else if (do_update) flap_pend <= 1'b0;

      if (state != RUN)       tick_pend <= 1'b0;
      else if (do_update)     tick_pend <= 1'b0;
      else if (tick && busy)  tick_pend <= 1'b1;

      if (frame_valid_o) begin
        if (frame_done_i) frame_valid_o <= 1'b0;
      end else if (frame_req) begin
        frame_o       <= frame_img;
        frame_valid_o <= 1'b1;
        frame_req     <= 1'b0;
      end
      if (do_update || new_game) frame_req <= 1'b1;
    end
  end

endmodule

// File: doc/flappy_frame_gen.md
# flappy_frame_gen

Game-logic stage that sits directly upstream of the LED-matrix display driver. It runs the Flappy Bird game on a GS×GS grid: bird gravity and flap, a scrolling pipe with a pseudo-random gap, collision detection and score. Each new game state is rendered into a GS·GS-bit frame and handed to the display driver with a valid/done handshake. The frame port drives the driver's matrix input, valid drives its enable, and the driver's done output returns here.

## Interface
- GS, 8: grid size; power of two, ≥4.
- TICK_COUNT, 24'd10_000_000: clock cycles per game tick.

- clk  in  1  system clock (single clock domain)
- reset  in  1  synchronous, active-high reset
- flap_i  in  1  flap button, level; rising edge detected internally
- frame_done_i  in  1  display driver finished showing current frame
- frame_o  out  GS*GS  bitmap; bit r*GS+c = row r (0 = top), column c (0 = left)
- frame_valid_o  out  1  frame_o holds a new frame, stable while high
- score_o  out  8  pipes passed, saturates at 255
- game_over_o  out  1  high in OVER state

## Operation
- Game FSM states: IDLE, RUN, OVER.
- Reset / new game values: bird_row=GS/2, pipe_col=GS-1, gap_top=2, lfsr=8'hA5, score=0, tick counter=0, state IDLE, one frame requested.
- Flap edge: `flap_q` register; edge = flap_i & ~flap_q.
  - IDLE: edge → RUN.
  - RUN: edge sets flap_pend.
  - OVER: edge → new-game values, state IDLE, one frame requested.
- Tick counter counts 0..TICK_COUNT-1 in RUN only. The tick pulse occurs at TICK_COUNT-1, then the counter wraps to 0.
- Update, applied in RUN in this order:
  - **Bird:**
    - flap_pend → bird_row -= 2, saturating at 0, and flap_pend clears.
    - Otherwise, at bird_row==GS-1 → OVER (row unchanged).
    - Otherwise bird_row += 1.
  - **Pipe:**
    - pipe_col==0 → pipe_col=GS-1; lfsr steps once (shift left, feedback bit0 = q7^q5^q4^q3); new gap_top = lfsr[log2(GS)-1:0] of the stepped value, minus (GS-2) if it exceeds GS-3.
    - Otherwise pipe_col -= 1.
  - **Collision:** new pipe_col==1 and bird_row outside gap_top..gap_top+2 → OVER.
  - **Score:** new pipe_col==0 → score += 1 (saturating).
- Every update, including the transition to OVER, requests a frame.
- Frame content:
  - Bird at (bird_row, 1).
  - In RUN/OVER, all rows of column pipe_col are lit except gap_top..gap_top+2.
  - IDLE shows the bird only.
  - A bird overlapping the pipe is lit (OR).

## Timing
- Reset outputs: frame_o=0, frame_valid_o=0, score_o=0, game_over_o=0.
- Handshake:
  - A frame request with frame_valid_o=0 latches frame_o and raises frame_valid_o on the next edge.
  - frame_valid_o stays high, with frame_o constant, until frame_done_i is sampled high. frame_valid_o is low on the following edge.
  - frame_done_i is ignored while frame_valid_o=0.
- A tick is applied only while frame_valid_o=0.
  - A tick arriving while frame_valid_o=1 sets a one-deep tick_pend.
  - Further ticks in that window are dropped.
  - tick_pend is applied in the first cycle with frame_valid_o=0.
- Update latency: frame_valid_o rises 1 cycle after the update cycle.
- After reset deasserts, the first edge builds the IDLE frame. frame_valid_o is high one cycle after that.
- A simultaneous tick and flap edge: the flap is pended and consumed by the next tick, not the current one.
- Reset mid-handshake: frame_valid_o drops immediately and the game restarts.

## Test plan
GS=8, TICK_COUNT=4, frame_done_i pulsed 1 cycle after each valid unless stated.
- Reset:
  - All outputs 0.
  - First frame_valid_o has frame_o = 1<<33 (row 4, col 1).
  - No ticks while in IDLE.
- Start + gravity: a flap edge starts RUN, with no further flaps.
  - Tick 1: bird_row 5, pipe_col 6, column 6 rows {0,1,5,6,7} lit.
  - Tick 4 (bird at 7): game_over_o=1.
- Flap every tick:
  - Bird rows 2,0,0,0,0; pipe reaches col 1 at tick 6 with gap 2..4.
  - Collision: game_over_o=1, score_o=0.
  - Next flap edge → IDLE frame 1<<33, score 0.
- Pass and wrap:
  - Flap pattern F,G,G,F,G,G,F gives rows 2,3,4,2,3,4,2, with no collision.
  - After tick 7, score_o=1.
  - Tick 8: pipe_col 7, lfsr 8'h4A, gap_top 2.
- Backpressure:
  - Hold frame_done_i low for 20 cycles: frame_o constant, exactly one pending update applied after done.
  - The frame after done reflects a single step only.
- Reset asserted while frame_valid_o=1: next cycle frame_valid_o=0, score_o=0, IDLE frame reissued.
